// File: rtl/ps2_rx_teclado.sv
// PS/2 keyboard receiver: deserializes device-to-host frames and delivers
// make codes as key_code plus a one-cycle en_codigo strobe; break sequences are swallowed.
module ps2_rx_teclado #(
   parameter int N       = 8,
   parameter int FILT    = 8,
   parameter int TIMEOUT = 200000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   output logic [N-1:0] key_code,
   output logic         en_codigo,
   output logic         ext,
   output logic         err_frame
);

   localparam int FW = $clog2(FILT + 1);
   localparam int BW = (N > 1) ? $clog2(N) : 1;
   localparam logic [17:0]   TMO_LAST = 18'(TIMEOUT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
   localparam logic [N-1:0]  CODE_BRK = N'(8'hF0);
   localparam logic [N-1:0]  CODE_EXT = N'(8'hE0);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          clk_f, clk_f_q;
   logic [FW-1:0] flt_cnt;
   logic          fall;

   state_t        state, state_n;
   logic [BW-1:0] bit_cnt, bit_cnt_n;
   logic [N-1:0]  shreg, shreg_n;
   logic          par_ok, par_ok_n;
   logic          brk, brk_n;
   logic          e0, e0_n;
   logic [17:0]   tmo, tmo_n;
   logic [N-1:0]  key_n;
   logic          ext_n, en_n, err_n;

   // NOTE: reset is synchronous, so every register is reset inside its clocked block.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // The filtered clock only flips after FILT consecutive samples disagree with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_f   <= 1'b1;
         clk_f_q <= 1'b1;
         flt_cnt <= '0;
      end else begin
         clk_f_q <= clk_f;
         if (clk_s2 == clk_f) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILT - 1)) begin
            clk_f   <= clk_s2;
            flt_cnt <= '0;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   assign fall = clk_f_q & ~clk_f;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_ok_n  = par_ok;
      brk_n     = brk;
      e0_n      = e0;
      tmo_n     = (state == IDLE) ? 18'd0 : tmo + 18'd1;
      key_n     = key_code;
      ext_n     = ext;
      en_n      = 1'b0;
      err_n     = 1'b0;

      if (fall) begin
         tmo_n = 18'd0;
         case (state)
            IDLE: begin
               if (!dat_s2) begin
                  state_n   = DATA;
                  bit_cnt_n = '0;
               end
            end
            DATA: begin
               shreg_n   = {dat_s2, shreg[N-1:1]};
               bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == BIT_LAST) state_n = PARITY;
            end
            PARITY: begin
               par_ok_n = ^{shreg, dat_s2};
               state_n  = STOP;
            end
            STOP: begin
               state_n = IDLE;
               if (dat_s2 && par_ok) begin
                  if (shreg == CODE_BRK) begin
                     brk_n = 1'b1;
                  end else if (shreg == CODE_EXT) begin
                     e0_n = 1'b1;
                  end else if (brk) begin
                     brk_n = 1'b0;
                     e0_n  = 1'b0;
                  end else begin
                     key_n = shreg;
                     ext_n = e0;
                     en_n  = 1'b1;
                     e0_n  = 1'b0;
                  end
               end else begin
                  err_n = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end else if (state != IDLE && tmo == TMO_LAST) begin
         // Abandon a stalled frame; break/E0 flags survive.
         state_n = IDLE;
         tmo_n   = 18'd0;
         err_n   = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_ok    <= 1'b0;
         brk       <= 1'b0;
         e0        <= 1'b0;
         tmo       <= 18'd0;
         key_code  <= '0;
         ext       <= 1'b0;
         en_codigo <= 1'b0;
         err_frame <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shreg     <= shreg_n;
         par_ok    <= par_ok_n;
         brk       <= brk_n;
         e0        <= e0_n;
         tmo       <= tmo_n;
         key_code  <= key_n;
         ext       <= ext_n;
         en_codigo <= en_n;
         err_frame <= err_n;
      end
   end

endmodule

// File: tb/tb_ps2_rx_teclado.sv
// Self-checking bench for ps2_rx_teclado: a byte-level keyboard model predicts
// the ordered strobes and held key_code/ext; a compare process checks every cycle.
module tb_ps2_rx_teclado;

   localparam int N       = 8;
   localparam int FILT    = 8;
   localparam int TIMEOUT = 2000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ps2_clk = 1'b1;
   logic         ps2_data = 1'b1;
   logic [N-1:0] key_code;
   logic         en_codigo, ext, err_frame;

   ps2_rx_teclado #(.N(N), .FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .key_code (key_code),
      .en_codigo(en_codigo),
      .ext      (ext),
      .err_frame(err_frame)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_err;
      logic [7:0] code;
      bit         ext;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       cmp_e;
   exp_t       drv_e;
   int         total = 0;
   int         bad   = 0;
   bit         m_brk = 1'b0;
   bit         m_e0  = 1'b0;
   logic [7:0] m_key = 8'h00;
   bit         m_ext = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Keyboard protocol model at byte granularity.
   task automatic model_frame(input logic [7:0] b, input bit good);
      if (!good) begin
         drv_e.is_err = 1'b1; drv_e.code = 8'h00; drv_e.ext = 1'b0;
         exp_q.push_back(drv_e);
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (b == 8'hE0) begin
         m_e0 = 1'b1;
      end else if (m_brk) begin
         m_brk = 1'b0;
         m_e0  = 1'b0;
      end else begin
         drv_e.is_err = 1'b0; drv_e.code = b; drv_e.ext = m_e0;
         exp_q.push_back(drv_e);
         m_e0 = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         m_key = 8'h00;
         m_ext = 1'b0;
      end else begin
         check("strobe_overlap", {31'b0, en_codigo & err_frame}, 32'd0);
         if (en_codigo || err_frame) begin
            if (exp_q.size() == 0) begin
               check("spurious_strobe", {30'b0, en_codigo, err_frame}, 32'd0);
            end else begin
               cmp_e = exp_q.pop_front();
               check("strobe_kind", {30'b0, en_codigo, err_frame}, cmp_e.is_err ? 32'd1 : 32'd2);
               if (!cmp_e.is_err) begin
                  m_key = cmp_e.code;
                  m_ext = cmp_e.ext;
               end
            end
         end
         check("key_code_hold", {24'b0, key_code}, {24'b0, m_key});
         check("ext_hold", {31'b0, ext}, {31'b0, m_ext});
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic v, input int hp, input bit glitch);
      ps2_data = v;
      if (glitch) begin
         wait_cyc(2);
         ps2_clk = 1'b0;
         wait_cyc(FILT - 2);
         ps2_clk = 1'b1;
      end
      wait_cyc(hp);
      ps2_clk = 1'b0;
      wait_cyc(hp);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int hp, input int glitch_at);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      model_frame(b, !bad_par && !bad_stop);
      for (int i = 0; i < 11; i++) ps2_bit(bits[i], hp, i == glitch_at);
      ps2_data = 1'b1;
      wait_cyc(FILT + 12);
      check("queue_drained", exp_q.size(), 32'd0);
   endtask

   task automatic send_partial(input int nbits, input int hp);
      ps2_bit(1'b0, hp, 1'b0);
      for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)), hp, 1'b0);
      ps2_data = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      int         sel;
      rst = 1'b1;
      wait_cyc(4);
      rst = 1'b0;
      wait_cyc(2);
      check("rst_key_code", {24'b0, key_code}, 32'h00);
      check("rst_ext", {31'b0, ext}, 32'd0);
      check("rst_en_codigo", {31'b0, en_codigo}, 32'd0);
      check("rst_err_frame", {31'b0, err_frame}, 32'd0);

      send_frame(8'h75, 1'b0, 1'b0, 15, -1);
      check("lit_make_75", {24'b0, key_code}, 32'h75);
      check("lit_make_75_ext", {31'b0, ext}, 32'd0);

      send_frame(8'h72, 1'b0, 1'b0, 14, -1);
      send_frame(8'hF0, 1'b0, 1'b0, 14, -1);
      send_frame(8'h72, 1'b0, 1'b0, 14, -1);
      check("lit_release_72", {24'b0, key_code}, 32'h72);

      send_frame(8'hE0, 1'b0, 1'b0, 16, -1);
      send_frame(8'h75, 1'b0, 1'b0, 16, -1);
      check("lit_ext_75", {24'b0, key_code}, 32'h75);
      check("lit_ext_75_ext", {31'b0, ext}, 32'd1);
      send_frame(8'hE0, 1'b0, 1'b0, 16, -1);
      send_frame(8'hF0, 1'b0, 1'b0, 16, -1);
      send_frame(8'h75, 1'b0, 1'b0, 16, -1);
      send_frame(8'h72, 1'b0, 1'b0, 16, -1);
      check("lit_after_ext_72", {24'b0, key_code}, 32'h72);
      check("lit_after_ext_ext", {31'b0, ext}, 32'd0);

      send_frame(8'h75, 1'b1, 1'b0, 15, -1);
      check("lit_bad_parity_hold", {24'b0, key_code}, 32'h72);
      send_frame(8'h75, 1'b0, 1'b0, 15, -1);

      drv_e.is_err = 1'b1; drv_e.code = 8'h00; drv_e.ext = 1'b0;
      exp_q.push_back(drv_e);
      send_partial(4, 15);
      wait_cyc(TIMEOUT + 20);
      check("timeout_drained", exp_q.size(), 32'd0);
      send_frame(8'h72, 1'b0, 1'b0, 15, -1);
      check("lit_after_timeout", {24'b0, key_code}, 32'h72);

      send_frame(8'h75, 1'b0, 1'b0, 15, 0);
      check("lit_glitch_idle", {24'b0, key_code}, 32'h75);
      send_frame(8'h72, 1'b0, 1'b0, 15, 4);
      check("lit_glitch_mid", {24'b0, key_code}, 32'h72);

      send_partial(5, 15);
      wait_cyc(3);
      rst   = 1'b1;
      m_brk = 1'b0;
      m_e0  = 1'b0;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(2);
      check("lit_midframe_rst", {24'b0, key_code}, 32'h00);
      send_frame(8'h75, 1'b0, 1'b0, 15, -1);
      check("lit_after_rst_75", {24'b0, key_code}, 32'h75);

      for (int k = 0; k < 40; k++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       b = 8'hF0;
            1:       b = 8'hE0;
            2:       b = 8'h75;
            3:       b = 8'h72;
            default: b = 8'($urandom);
         endcase
         send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    int'($urandom_range(12, 20)),
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1);
      end

      wait_cyc(20);
      check("final_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
